// File: rtl/cdc_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cdc_rst_sequencer
// Description : Per-domain reset sequencer. Reset assertion is asynchronous,
//               release is synchronised and staggered by index. A soft reset
//               re-runs the same release sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_rst_sequencer #(
    parameter int NUM_RST   = 3,
    parameter int SYNC_FF   = 4,
    parameter int PULSE_MIN = 8,
    parameter int STAGE_DLY = 16
) (
    input  logic               clk,
    input  logic               async_clr,
    input  logic               soft_req,
    output logic               soft_ack,
    output logic [NUM_RST-1:0] rst_out,
    output logic               rst_done
);

    localparam int c_CNT_MAX = (PULSE_MIN > STAGE_DLY) ? PULSE_MIN : STAGE_DLY;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = $clog2(NUM_RST + 1);

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(PULSE_MIN - 1);
    localparam logic [c_CNT_W-1:0] c_STAGE_LAST = c_CNT_W'(STAGE_DLY - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_RST - 1);

    localparam logic [1:0] S_WAIT    = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    (* async_reg = "true" *) logic [SYNC_FF-1:0] r_sync;
    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic                w_rst_sync;
    logic                w_hold_exit;

    always_ff @(posedge clk or posedge async_clr) begin
        if (async_clr) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_FF-2:0], 1'b0};
        end
    end

    assign w_rst_sync = r_sync[SYNC_FF-1];

    // The edge that leaves WAIT already counts as the first hold cycle, so
    // bit 0 falls exactly PULSE_MIN edges after the synchroniser releases.
    assign w_hold_exit = ((r_state == S_WAIT) && !w_rst_sync && (PULSE_MIN == 1)) ||
                         ((r_state == S_HOLD) && !soft_req && (r_cnt == c_HOLD_LAST));

    always_ff @(posedge clk or posedge async_clr) begin
        if (async_clr) begin
            r_state  <= S_WAIT;
            r_cnt    <= '0;
            r_idx    <= '0;
            rst_out  <= '1;
            rst_done <= 1'b0;
            soft_ack <= 1'b0;
        end else begin
            soft_ack <= 1'b0;
            if (w_hold_exit) begin
                rst_out[0] <= 1'b0;
                r_cnt      <= '0;
                r_idx      <= c_IDX_W'(1);
                r_state    <= (NUM_RST == 1) ? S_DONE : S_RELEASE;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (!w_rst_sync) begin
                            r_state <= S_HOLD;
                            r_cnt   <= c_CNT_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (!soft_req) begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    S_RELEASE: begin
                        if (r_cnt == c_STAGE_LAST) begin
                            for (int i = 0; i < NUM_RST; i++) begin
                                if (r_idx == c_IDX_W'(i)) begin
                                    rst_out[i] <= 1'b0;
                                end
                            end
                            r_cnt <= '0;
                            r_idx <= r_idx + c_IDX_W'(1);
                            if (r_idx == c_IDX_LAST) begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (soft_req) begin
                            rst_out  <= '1;
                            rst_done <= 1'b0;
                            soft_ack <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= S_HOLD;
                        end else begin
                            rst_done <= 1'b1;
                        end
                    end
                    default: r_state <= S_WAIT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdc_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_rst_sequencer
// Description : Self-checking bench for cdc_rst_sequencer (default and
//               minimum-parameter instances) against a schedule-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_rst_sequencer;

    logic       clk = 1'b0;
    logic       async_clr;
    logic       soft_req;
    logic       soft_ack_a, rst_done_a;
    logic [2:0] rst_out_a;
    logic       soft_ack_b, rst_done_b;
    logic [0:0] rst_out_b;

    always #5 clk = ~clk;

    cdc_rst_sequencer #(
        .NUM_RST(3), .SYNC_FF(4), .PULSE_MIN(8), .STAGE_DLY(16)
    ) u_dut_main (
        .clk(clk), .async_clr(async_clr), .soft_req(soft_req),
        .soft_ack(soft_ack_a), .rst_out(rst_out_a), .rst_done(rst_done_a)
    );

    cdc_rst_sequencer #(
        .NUM_RST(1), .SYNC_FF(2), .PULSE_MIN(1), .STAGE_DLY(1)
    ) u_dut_corner (
        .clk(clk), .async_clr(async_clr), .soft_req(soft_req),
        .soft_ack(soft_ack_b), .rst_out(rst_out_b), .rst_done(rst_done_b)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    edge_n   = 0;
    string scen     = "init";

    // Model: index 0 = main instance, 1 = corner instance.
    int p_num[2]   = '{3, 1};
    int p_sync[2]  = '{4, 2};
    int p_pulse[2] = '{8, 1};
    int p_stage[2] = '{16, 1};

    int phase[2];       // 0: synchronising, 1: holding, 2: releasing/done
    int sync_left[2];
    int hold_left[2];
    int rel_edge[2];    // edge at which bit 0 fell
    bit first_hold[2];
    bit exp_ack[2];

    int fall_e[3];
    int done_e;
    int ack_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [31:0] exp_out(input int d);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < p_num[d]; i++)
            v[i] = !(phase[d] == 2 && edge_n >= rel_edge[d] + i * p_stage[d]);
        return v;
    endfunction

    function automatic logic [31:0] exp_done(input int d);
        return {31'b0, (phase[d] == 2 &&
                        edge_n >= rel_edge[d] + (p_num[d] - 1) * p_stage[d] + 1)};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            phase[d]     = 0;
            sync_left[d] = p_sync[d];
            rel_edge[d]  = -1;
            exp_ack[d]   = 1'b0;
        end
    endtask

    task automatic model_edge(input int d);
        exp_ack[d] = 1'b0;
        if (async_clr) begin
            phase[d]     = 0;
            sync_left[d] = p_sync[d];
            rel_edge[d]  = -1;
        end else begin
            case (phase[d])
                0: begin
                    sync_left[d]--;
                    if (sync_left[d] == 0) begin
                        phase[d]      = 1;
                        hold_left[d]  = p_pulse[d];
                        first_hold[d] = 1'b1;
                    end
                end
                1: begin
                    // Requests are ignored on the very first edge after release.
                    if (first_hold[d] || !soft_req) hold_left[d]--;
                    first_hold[d] = 1'b0;
                    if (hold_left[d] == 0) begin
                        phase[d]    = 2;
                        rel_edge[d] = edge_n;
                    end
                end
                default: begin
                    if (soft_req && edge_n > rel_edge[d] + (p_num[d] - 1) * p_stage[d]) begin
                        phase[d]      = 1;
                        hold_left[d]  = p_pulse[d];
                        first_hold[d] = 1'b0;
                        rel_edge[d]   = -1;
                        exp_ack[d]    = 1'b1;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        check_eq({scen, ":main_rst_out"},  {29'b0, rst_out_a},  exp_out(0));
        check_eq({scen, ":main_rst_done"}, {31'b0, rst_done_a}, exp_done(0));
        check_eq({scen, ":main_soft_ack"}, {31'b0, soft_ack_a}, {31'b0, exp_ack[0]});
        check_eq({scen, ":crn_rst_out"},   {31'b0, rst_out_b},  exp_out(1));
        check_eq({scen, ":crn_rst_done"},  {31'b0, rst_done_b}, exp_done(1));
        check_eq({scen, ":crn_soft_ack"},  {31'b0, soft_ack_b}, {31'b0, exp_ack[1]});
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    // Runs ncyc edges, logging when each main output first falls / done rises.
    task automatic run_track(input int ncyc);
        for (int i = 0; i < 3; i++) fall_e[i] = -1;
        done_e  = -1;
        ack_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            step();
            for (int i = 0; i < 3; i++)
                if (fall_e[i] < 0 && rst_out_a[i] == 1'b0) fall_e[i] = edge_n;
            if (done_e < 0 && rst_done_a) done_e = edge_n;
            if (soft_ack_a) ack_cnt++;
        end
    endtask

    // Asynchronous pulse placed between clock edges.
    task automatic glitch();
        #1;
        async_clr = 1'b1;
        #1;
        check_eq("async_assert_rst_out",  {29'b0, rst_out_a},  32'h7);
        check_eq("async_assert_rst_done", {31'b0, rst_done_a}, 32'h0);
        check_eq("async_assert_crn_out",  {31'b0, rst_out_b},  32'h1);
        async_clr = 1'b0;
        model_reset();
    endtask

    int e_ref;
    int a_ref;

    initial begin
        async_clr = 1'b1;
        soft_req  = 1'b0;
        model_reset();
        #1;
        scen = "reset";
        check_all();

        // Power-on release
        scen = "por";
        repeat (5) step();
        async_clr = 1'b0;
        e_ref = edge_n + p_sync[0];
        run_track(50);
        check_eq("por_bit0_time", fall_e[0] - e_ref, 8);
        check_eq("por_bit1_time", fall_e[1] - e_ref, 24);
        check_eq("por_bit2_time", fall_e[2] - e_ref, 40);
        check_eq("por_done_time", done_e - e_ref, 41);
        check_eq("por_no_ack", ack_cnt, 0);

        // Single-cycle soft request from DONE
        scen = "soft";
        soft_req = 1'b1;
        step();
        a_ref = edge_n;
        check_eq("soft_ack_pulse", {31'b0, soft_ack_a}, 32'h1);
        soft_req = 1'b0;
        run_track(50);
        check_eq("soft_bit0_time", fall_e[0] - a_ref, 8);
        check_eq("soft_bit2_time", fall_e[2] - a_ref, 40);

        // Stretched soft request held 30 cycles
        scen = "stretch";
        soft_req = 1'b1;
        run_track(30);
        check_eq("stretch_single_ack", ack_cnt, 1);
        check_eq("stretch_held", {29'b0, rst_out_a}, 32'h7);
        soft_req = 1'b0;
        a_ref = edge_n;
        run_track(50);
        check_eq("stretch_bit0_time", fall_e[0] - a_ref, 8);
        check_eq("stretch_bit1_time", fall_e[1] - a_ref, 24);

        // Request during RELEASE is ignored
        scen = "ignored";
        soft_req = 1'b1;
        step();
        a_ref = edge_n;
        soft_req = 1'b0;
        repeat (15) step();
        soft_req = 1'b1;
        step();
        soft_req = 1'b0;
        run_track(40);
        check_eq("ignored_no_ack", ack_cnt, 0);
        check_eq("ignored_done_time", done_e - a_ref, 41);

        // Asynchronous glitch after bit 0 released
        scen = "glitch";
        soft_req = 1'b1;
        step();
        soft_req = 1'b0;
        repeat (10) step();
        check_eq("glitch_pre_bit0", {31'b0, rst_out_a[0]}, 32'h0);
        glitch();
        e_ref = edge_n + p_sync[0];
        run_track(50);
        check_eq("glitch_bit0_time", fall_e[0] - e_ref, 8);
        check_eq("glitch_done_time", done_e - e_ref, 41);

        // Randomised soft requests and occasional asynchronous glitches
        scen = "random";
        for (int c = 0; c < 1500; c++) begin
            soft_req = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) glitch();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
